// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight to a variable-latency
// instruction memory and feeds IF/ID. Optional macro FETCH_ALIGN_CHK_EN flags odd redirect targets.
`timescale 1ns/1ps
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800,
   parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   input  logic        stall_in,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] instr_out,
   output logic [15:0] pc_next_out,
   output logic        valid_out,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [15:0] pc_r, pc_s;
   logic        squash_r, squash_s;
   logic [15:0] hold_r, hold_s;
   logic [15:0] instr_r, instr_s;
   logic [15:0] pc_next_r, pc_next_s;
   logic        valid_r, valid_s;
   logic        halted_r, halted_s;
   logic        err_r, err_s;
   logic        req_r, req_s;
   logic [15:0] addr_r, addr_s;
   logic        deliver_s;
   logic [15:0] word_s;
   logic [15:0] pc_inc_s;
   logic [15:0] target_s;
   logic        misalign_s;

`ifdef FETCH_ALIGN_CHK_EN
   assign target_s   = {redirect_pc[15:1], 1'b0};
   assign misalign_s = redirect_pc[0];
`else
   assign target_s   = redirect_pc;
   assign misalign_s = 1'b0;
`endif

   assign pc_inc_s = pc_r + 16'd2;

   // Select the word to hand to IF/ID this cycle: a fresh response or the held one
   always_comb begin
      deliver_s = 1'b0;
      word_s    = hold_r;
      case (state_r)
         ST_WAIT: begin
            if (imem_rvalid && !squash_r && !stall_in) begin
               deliver_s = 1'b1;
               word_s    = imem_rdata;
            end else begin
               deliver_s = 1'b0;
            end
         end
         ST_HOLD: begin
            if (!stall_in) begin
               deliver_s = 1'b1;
            end else begin
               deliver_s = 1'b0;
            end
         end
         default: deliver_s = 1'b0;
      endcase
   end

   // Next-state and next-output logic; redirect outranks delivery, which outranks the FSM
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      squash_s  = squash_r;
      hold_s    = hold_r;
      pc_next_s = pc_next_r;
      halted_s  = halted_r;
      err_s     = err_r;
      req_s     = 1'b0;
      addr_s    = addr_r;
      if (!stall_in) begin
         valid_s = 1'b0;
         instr_s = NOP_INSTR;
      end else begin
         valid_s = valid_r;
         instr_s = instr_r;
      end

      if (redirect) begin
         pc_s     = target_s;
         valid_s  = 1'b0;
         instr_s  = NOP_INSTR;
         halted_s = 1'b0;
         hold_s   = 16'h0000;
         err_s    = err_r | misalign_s;
         // A request still in flight must have its response swallowed later
         if ((state_r == ST_WAIT) && !imem_rvalid) begin
            squash_s = 1'b1;
            state_s  = ST_WAIT;
         end else begin
            squash_s = 1'b0;
            state_s  = ST_FETCH;
         end
      end else if (deliver_s) begin
         instr_s   = word_s;
         pc_next_s = pc_inc_s;
         valid_s   = 1'b1;
         pc_s      = pc_inc_s;
         hold_s    = 16'h0000;
         if (word_s[15:11] == HALT_OPC) begin
            state_s = ST_HALTED;
         end else begin
            req_s   = 1'b1;
            addr_s  = pc_inc_s;
            state_s = ST_WAIT;
         end
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (!stall_in) begin
                  req_s   = 1'b1;
                  addr_s  = pc_r;
                  state_s = ST_WAIT;
               end else begin
                  state_s = ST_FETCH;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid && squash_r) begin
                  squash_s = 1'b0;
                  state_s  = ST_FETCH;
               end else if (imem_rvalid) begin
                  hold_s  = imem_rdata;
                  state_s = ST_HOLD;
               end else begin
                  state_s = ST_WAIT;
               end
            end
            ST_HOLD:   state_s  = ST_HOLD;
            ST_HALTED: halted_s = 1'b1;
            default:   state_s  = ST_FETCH;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_FETCH;
         pc_r      <= RESET_PC;
         squash_r  <= 1'b0;
         hold_r    <= 16'h0000;
         instr_r   <= NOP_INSTR;
         pc_next_r <= 16'h0000;
         valid_r   <= 1'b0;
         halted_r  <= 1'b0;
         err_r     <= 1'b0;
         req_r     <= 1'b0;
         addr_r    <= 16'h0000;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         squash_r  <= squash_s;
         hold_r    <= hold_s;
         instr_r   <= instr_s;
         pc_next_r <= pc_next_s;
         valid_r   <= valid_s;
         halted_r  <= halted_s;
         err_r     <= err_s;
         req_r     <= req_s;
         addr_r    <= addr_s;
      end
   end

   assign imem_req    = req_r;
   assign imem_addr   = addr_r;
   assign instr_out   = instr_r;
   assign pc_next_out = pc_next_r;
   assign valid_out   = valid_r;
   assign halted      = halted_r;
   assign err         = err_r;

endmodule
